hwpe_multi_stream_engine_ctrl: RTL

Parametrised engine-control core for HWPE engines with N_OUT output streams. It sequences the kernel start, counts accepted beats per output stream, and raises done only when the kernel has reported done and every stream has moved its programmed beat count. It replaces the per-engine single-stream tracker/counter logic and sits between the HWPE controller FSM and the kernel adapter.

---
 rtl/hwpe_engine_ctrl_pkg.sv | 26 ++
 rtl/hwpe_stream_beat_counter.sv | 39 +++
 rtl/hwpe_multi_stream_engine_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/hwpe_engine_ctrl_pkg.sv
// Shared types for the HWPE multi-stream engine controller.
package hwpe_engine_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_K,
    START,
    RUN,
    DONE
  } engine_state_e;

  typedef struct packed {
    logic start;
    logic clear;
  } ctrl_engine_ctrl_t;

  typedef struct packed {
    logic done;
    logic ready;
    logic busy;
    logic err;
  } flags_engine_ctrl_t;

endpackage

// File: rtl/hwpe_stream_beat_counter.sv
// Per-stream saturating beat counter with completion compare and overrun detect.
module hwpe_stream_beat_counter
  import hwpe_engine_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             hs_i,
  input  logic [CNT_W-1:0] len_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             complete_o,
  output logic             overrun_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_sat;
  logic             w_beat;

  assign w_sat      = &r_cnt;
  assign w_beat     = en_i & hs_i;
  assign complete_o = (r_cnt >= len_i);
  // Overrun is judged against the count before this beat lands.
  assign overrun_o  = w_beat & complete_o;
  assign cnt_o      = r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (w_beat && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hwpe_multi_stream_engine_ctrl.sv
// Engine control: sequences kernel start, tracks per-stream beats, signals job done.
module hwpe_multi_stream_engine_ctrl
  import hwpe_engine_ctrl_pkg::*;
#(
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic [N_OUT*CNT_W-1:0]     len_i,
  input  logic                       kernel_done_i,
  input  logic                       kernel_ready_i,
  input  logic                       kernel_idle_i,
  input  logic [N_OUT-1:0]           out_valid_i,
  input  logic [N_OUT-1:0]           out_ready_i,
  output logic                       kernel_start_o,
  output logic [N_OUT*(DATA_W/8)-1:0] out_strb_o,
  output logic [N_OUT*CNT_W-1:0]     cnt_o,
  output logic                       done_o,
  output logic                       ready_o,
  output logic                       busy_o,
  output logic                       err_o
);

  engine_state_e                  r_state;
  engine_state_e                  w_state_nxt;
  logic [N_OUT-1:0][CNT_W-1:0]    r_len;
  logic [N_OUT-1:0][CNT_W-1:0]    w_cnt;
  logic [N_OUT-1:0]               w_complete;
  logic [N_OUT-1:0]               w_overrun;
  logic                           r_kdone_seen;
  logic                           r_err;
  logic                           r_done;
  logic                           r_kstart;
  logic                           r_ready;
  logic                           w_kavail;
  logic                           w_cnt_en;
  logic                           w_job_start;
  logic                           w_cnt_clr;
  ctrl_engine_ctrl_t              w_ctrl;
  flags_engine_ctrl_t             w_flags;

  assign w_ctrl      = '{start: start_i, clear: clear_i};
  assign w_kavail    = kernel_ready_i | kernel_idle_i;
  assign w_cnt_en    = (r_state == START) || (r_state == RUN) || (r_state == DONE);
  assign w_job_start = (r_state == IDLE) && w_ctrl.start;
  assign w_cnt_clr   = w_ctrl.clear | w_job_start;

  for (genvar k = 0; k < N_OUT; k++) begin : g_chan
    hwpe_stream_beat_counter #(
      .CNT_W (CNT_W)
    ) i_beat_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (w_cnt_en),
      .clr_i      (w_cnt_clr),
      .hs_i       (out_valid_i[k] & out_ready_i[k]),
      .len_i      (r_len[k]),
      .cnt_o      (w_cnt[k]),
      .complete_o (w_complete[k]),
      .overrun_o  (w_overrun[k])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_ctrl.start) w_state_nxt = w_kavail ? START : WAIT_K;
      WAIT_K:  if (w_kavail) w_state_nxt = START;
      START:   w_state_nxt = RUN;
      RUN:     if (r_kdone_seen && (&w_complete)) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_ctrl.clear) w_state_nxt = IDLE;
  end

  // Pulse outputs are registered from the next state so they align with the state itself.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_kdone_seen <= 1'b0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_kstart     <= 1'b0;
      r_ready      <= 1'b0;
    end else if (w_ctrl.clear) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_kdone_seen <= 1'b0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
      r_kstart     <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_kstart <= (w_state_nxt == START);
      r_done   <= (w_state_nxt == DONE);
      r_ready  <= (w_state_nxt == IDLE) && w_kavail;
      if (w_job_start) begin
        r_len        <= len_i;
        r_err        <= 1'b0;
        r_kdone_seen <= 1'b0;
      end else begin
        if (|w_overrun) r_err <= 1'b1;
        if (((r_state == START) || (r_state == RUN)) && kernel_done_i) r_kdone_seen <= 1'b1;
      end
    end
  end

  assign w_flags = '{done: r_done, ready: r_ready, busy: (r_state != IDLE), err: r_err};

  assign kernel_start_o = r_kstart;
  assign out_strb_o     = '1;
  assign cnt_o          = w_cnt;
  assign done_o         = w_flags.done;
  assign ready_o        = w_flags.ready;
  assign busy_o         = w_flags.busy;
  assign err_o          = w_flags.err;

endmodule
